activation_tile_feeder: RTL

// - Upstream of the per-row delay-skew stage: buffers SA_SIZE-wide activation vectors from the

---
 rtl/activation_tile_feeder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/activation_tile_feeder.sv
`timescale 1ns/1ps
// activation_tile_feeder
// Buffers SA_SIZE-lane activation vectors in a FIFO and presents exactly one
// vector per cycle to the delay-skew stage. When no data is queued it drives
// zero bubbles. After the last vector of a tile it drives FLUSH_CYCLES zero
// vectors so the skewed data drains out of the array.
//
// Ports
//   clk, resetn      clock and synchronous active-low reset
//   in_valid/ready   producer handshake (ready = FIFO not full)
//   in_data/in_last  vector lanes and end-of-tile marker
//   outputs          registered vector to the skew stage (zero when not valid)
//   out_valid        outputs holds real data
//   tile_done        one-cycle pulse with the final flush vector
//   busy             FSM not idle
//   stat_tiles/stat_bubbles  only when FEEDER_STATS_EN is defined
//
// Optional feature macro: FEEDER_STATS_EN
module activation_tile_feeder #(
    parameter int unsigned SA_SIZE         = 8,
    parameter int unsigned ACTIVATION_SIZE = 32,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned FLUSH_CYCLES    = 2 * SA_SIZE - 1
) (
    input  logic                                           clk,
    input  logic                                           resetn,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]        in_data,
    input  logic                                           in_last,
    output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]        outputs,
    output logic                                           out_valid,
    output logic                                           tile_done,
    output logic                                           busy
`ifdef FEEDER_STATS_EN
    ,
    output logic [31:0]                                    stat_tiles,
    output logic [31:0]                                    stat_bubbles
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FLS_W = $clog2(FLUSH_CYCLES + 1);

    typedef logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] vec_t;

    typedef struct packed {
        logic last;
        vec_t data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_e;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    state_e             state_q, state_d;
    logic [FLS_W-1:0]   flush_cnt_q, flush_cnt_d;
    vec_t               outputs_d;
    logic               out_valid_d, tile_done_d;

    logic               empty_c, full_c, push_c, pop_c, bubble_c;
    entry_t             head_c;

    assign empty_c  = (count_q == '0);
    assign full_c   = (count_q == CNT_W'(DEPTH));
    assign in_ready = !full_c;
    assign push_c   = in_valid && !full_c;
    assign head_c   = mem_q[rd_ptr_q];
    assign busy     = (state_q != IDLE);

    // FIFO storage; contents need no reset since pointers/count are cleared
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{last: in_last, data: in_data};
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        outputs_d   = '0;
        out_valid_d = 1'b0;
        tile_done_d = 1'b0;
        pop_c       = 1'b0;
        bubble_c    = 1'b0;

        case (state_q)
            IDLE, STREAM: begin
                if (!empty_c) begin
                    pop_c       = 1'b1;
                    outputs_d   = head_c.data;
                    out_valid_d = 1'b1;
                    if (head_c.last) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLS_W'(FLUSH_CYCLES);
                    end else begin
                        state_d = STREAM;
                    end
                end else if (state_q == STREAM) begin
                    // Starved mid-tile: zero bubble, keep streaming
                    bubble_c = 1'b1;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - FLS_W'(1);
                if (flush_cnt_q == FLS_W'(1)) begin
                    tile_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Full blocks push, so push and pop never overflow the count
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // State, pointers and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
            outputs     <= '0;
            out_valid   <= 1'b0;
            tile_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
            outputs     <= outputs_d;
            out_valid   <= out_valid_d;
            tile_done   <= tile_done_d;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

`ifdef FEEDER_STATS_EN
    // Free-running statistics, wrap at 2^32; tile count moves with tile_done
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_tiles   <= '0;
            stat_bubbles <= '0;
        end else begin
            if (tile_done_d) begin
                stat_tiles <= stat_tiles + 32'(1);
            end
            if (bubble_c) begin
                stat_bubbles <= stat_bubbles + 32'(1);
            end
        end
    end
`endif

endmodule
